// File: rtl/vec_strided_lsu_if.sv
// PicoRV32 native memory port shared by the strided LSU (master) and memory (slave).
interface vec_strided_lsu_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store engine: one native-bus transaction per element,
// SEW 8/16/32, vl clamped to VLEN/SEW, stops early on a misaligned element.
module vec_strided_lsu #(
  parameter int VLEN = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [31:0]       cmd_base,
  input  logic [31:0]       cmd_stride,
  input  logic [31:0]       cmd_vl,
  input  logic [1:0]        cmd_sew,
  input  logic [VLEN-1:0]   st_data,
  output logic [VLEN-1:0]   ld_data,
  output logic              done,
  output logic              err,
  vec_strided_lsu_if.master mem
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic            store_r;
  logic [1:0]      sew_r;
  logic [31:0]     stride_r;
  logic [31:0]     addr_r;
  logic [31:0]     idx_r;
  logic [31:0]     n_r;
  logic [VLEN-1:0] st_r;
  logic [VLEN-1:0] ld_data_r;
  logic            cmd_ready_r;
  logic            done_r;
  logic            err_r;
  logic            mem_valid_r;
  logic [31:0]     mem_addr_r;
  logic [31:0]     mem_wdata_r;
  logic [3:0]      mem_wstrb_r;

  logic [1:0]      acc_sew_s;
  logic [31:0]     acc_lanes_s;
  logic [31:0]     acc_n_s;
  logic [31:0]     acc_wdata_s;
  logic [31:0]     next_addr_s;
  logic [31:0]     next_idx_s;
  logic [31:0]     next_wdata_s;
  logic [31:0]     ld_elem_s;
  logic [VLEN-1:0] ld_merge_s;

  function automatic logic [1:0] norm_sew(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] s);
    case (s)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      default: return lo[1] | lo[0];
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] lo, input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 32'h0000_00ff;
      2'd1:    return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] e, input logic [1:0] s);
    case (s)
      2'd0:    return {4{e[7:0]}};
      2'd1:    return {2{e[15:0]}};
      default: return e;
    endcase
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] idx, input logic [1:0] s);
    return idx << (32'd3 + 32'(s));
  endfunction

  function automatic logic [31:0] lane(input logic [VLEN-1:0] v, input logic [31:0] idx,
                                       input logic [1:0] s);
    return 32'(v >> lane_shift(idx, s));
  endfunction

  // Accept-time decode and per-element next values
  always_comb begin
    acc_sew_s    = norm_sew(cmd_sew);
    acc_lanes_s  = 32'(VLEN) >> (32'd3 + 32'(acc_sew_s));
    acc_n_s      = (cmd_vl < acc_lanes_s) ? cmd_vl : acc_lanes_s;
    acc_wdata_s  = replicate(lane(st_data, 32'd0, acc_sew_s), acc_sew_s);
    next_addr_s  = addr_r + stride_r;
    next_idx_s   = idx_r + 32'd1;
    next_wdata_s = replicate(lane(st_r, next_idx_s, sew_r), sew_r);
    ld_elem_s    = (mem.mem_rdata >> {addr_r[1:0], 3'b000}) & sew_mask(sew_r);
    ld_merge_s   = ld_data_r | (VLEN'(ld_elem_s) << lane_shift(idx_r, sew_r));
  end

  // Command FSM with registered bus and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      store_r     <= 1'b0;
      sew_r       <= 2'd0;
      stride_r    <= 32'd0;
      addr_r      <= 32'd0;
      idx_r       <= 32'd0;
      n_r         <= 32'd0;
      st_r        <= '0;
      ld_data_r   <= '0;
      cmd_ready_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wstrb_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            store_r     <= cmd_store;
            stride_r    <= cmd_stride;
            sew_r       <= acc_sew_s;
            st_r        <= st_data;
            addr_r      <= cmd_base;
            idx_r       <= 32'd0;
            n_r         <= acc_n_s;
            ld_data_r   <= '0;
            cmd_ready_r <= 1'b0;
            if (acc_n_s == 32'd0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              err_r   <= 1'b0;
            end else if (misaligned(cmd_base[1:0], acc_sew_s)) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
            end else begin
              state_r     <= ST_REQ;
              mem_valid_r <= 1'b1;
              mem_addr_r  <= {cmd_base[31:2], 2'b00};
              mem_wstrb_r <= cmd_store ? strobe(cmd_base[1:0], acc_sew_s) : 4'd0;
              mem_wdata_r <= cmd_store ? acc_wdata_s : 32'd0;
            end
          end
        end
        ST_REQ: begin
          if (mem_valid_r && mem.mem_ready) begin
            if (!store_r) begin
              ld_data_r <= ld_merge_s;
            end
            addr_r <= next_addr_s;
            idx_r  <= next_idx_s;
            // Last element or a misaligned successor both end the command here
            if (next_idx_s == n_r || misaligned(next_addr_s[1:0], sew_r)) begin
              state_r     <= ST_DONE;
              done_r      <= 1'b1;
              err_r       <= (next_idx_s != n_r);
              mem_valid_r <= 1'b0;
              mem_wstrb_r <= 4'd0;
            end else begin
              mem_addr_r  <= {next_addr_s[31:2], 2'b00};
              mem_wstrb_r <= store_r ? strobe(next_addr_s[1:0], sew_r) : 4'd0;
              mem_wdata_r <= store_r ? next_wdata_s : 32'd0;
            end
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          mem_valid_r <= 1'b0;
          mem_wstrb_r <= 4'd0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign ld_data       = ld_data_r;
  assign done          = done_r;
  assign err           = err_r;
  assign mem.mem_valid = mem_valid_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign mem.mem_wstrb = mem_wstrb_r;
endmodule

// File: tb/tb_vec_strided_lsu.sv
// Directed bench for vec_strided_lsu against a one-cycle-latency native-bus memory.
module tb_vec_strided_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         cmd_valid, cmd_ready, cmd_store, done, err, mem_init;
  logic [31:0]  cmd_base, cmd_stride, cmd_vl;
  logic [1:0]   cmd_sew;
  logic [255:0] st_data, ld_data, exp_v;

  vec_strided_lsu_if bus();

  logic [31:0] mem       [0:255];
  logic [31:0] log_addr  [0:127];
  logic [31:0] log_wdata [0:127];
  logic [3:0]  log_wstrb [0:127];
  int n_txn = 0;
  int n_err = 0;
  int n_chk = 0;
  int t0;

  vec_strided_lsu #(.VLEN(256)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_store (cmd_store),
    .cmd_base  (cmd_base),
    .cmd_stride(cmd_stride),
    .cmd_vl    (cmd_vl),
    .cmd_sew   (cmd_sew),
    .st_data   (st_data),
    .ld_data   (ld_data),
    .done      (done),
    .err       (err),
    .mem       (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      100:     return 32'h0403_0201;
      101:     return 32'h0807_0605;
      102:     return 32'h0c0b_0a09;
      103:     return 32'h000f_0e0d;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  // Bench memory: ready one cycle after valid, guarded against double service
  always @(posedge clk) begin
    bus.mem_ready <= 1'b0;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (resetn && bus.mem_valid && !bus.mem_ready) begin
      bus.mem_ready <= 1'b1;
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      log_addr[n_txn[6:0]]  <= bus.mem_addr;
      log_wdata[n_txn[6:0]] <= bus.mem_wdata;
      log_wstrb[n_txn[6:0]] <= bus.mem_wstrb;
      n_txn <= n_txn + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic st, input logic [31:0] base,
                         input logic [31:0] stride, input logic [31:0] vl, input logic [1:0] sew,
                         input logic [255:0] sd, input int exp_lat, input logic exp_err,
                         input int exp_txn);
    int lat;
    @(negedge clk);
    t0 = n_txn;
    cmd_valid = 1'b1; cmd_store = st; cmd_base = base; cmd_stride = stride;
    cmd_vl = vl; cmd_sew = sew; st_data = sd;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_done"}, 256'(done), 256'(1));
    check_eq({tag, "_lat"}, 256'(lat), 256'(exp_lat));
    check_eq({tag, "_err"}, 256'(err), 256'(exp_err));
    check_eq({tag, "_txn"}, 256'(n_txn - t0), 256'(exp_txn));
    @(negedge clk);
    check_eq({tag, "_ready"}, 256'({cmd_ready, done}), 256'(2'b10));
  endtask

  logic [3:0] strb_or;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; mem_init = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0;
    cmd_base = 32'd0; cmd_stride = 32'd0; cmd_vl = 32'd0; cmd_sew = 2'd0; st_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 256'(cmd_ready), 256'(1));
    check_eq("rst_bus", 256'({bus.mem_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}), 256'(0));
    check_eq("rst_ld", ld_data, 256'(0));
    check_eq("rst_flags", 256'({done, err}), 256'(0));
    mem_init = 1'b0;
    resetn = 1'b1;

    // SEW8 load, stride 2
    run_cmd("ld8", 1'b0, 32'd400, 32'd2, 32'd8, 2'd0, '0, 17, 1'b0, 8);
    check_eq("ld8_data", ld_data, 256'h0f0d0b0907050301);
    strb_or = 4'd0;
    for (int k = 0; k < 8; k++) strb_or = strb_or | log_wstrb[7'(t0 + k)];
    check_eq("ld8_wstrb", 256'(strb_or), 256'(0));
    check_eq("ld8_addr0", 256'(log_addr[7'(t0)]), 256'(400));
    check_eq("ld8_addr7", 256'(log_addr[7'(t0 + 7)]), 256'(412));

    // SEW16 store, stride 4
    run_cmd("st16", 1'b1, 32'd600, 32'd4, 32'd3, 2'd1, 256'h333322221111, 7, 1'b0, 3);
    for (int k = 0; k < 3; k++) begin
      check_eq("st16_addr", 256'(log_addr[7'(t0 + k)]), 256'(600 + 4 * k));
      check_eq("st16_wstrb", 256'(log_wstrb[7'(t0 + k)]), 256'(4'b0011));
      check_eq("st16_wdata", 256'(log_wdata[7'(t0 + k)]), 256'(32'h11111111 * (k + 1)));
    end
    check_eq("st16_mem0", 256'(mem[150]), 256'(32'hA500_1111));
    check_eq("st16_mem2", 256'(mem[152]), 256'(32'hA500_3333));

    // SEW32 load, negative stride
    run_cmd("ld32n", 1'b0, 32'd412, 32'hFFFF_FFFC, 32'd4, 2'd2, '0, 9, 1'b0, 4);
    check_eq("ld32n_data", ld_data, 256'h04030201080706050c0b0a09000f0e0d);
    check_eq("ld32n_addr3", 256'(log_addr[7'(t0 + 3)]), 256'(400));

    // Misaligned second element, then misaligned first element
    run_cmd("mis16", 1'b0, 32'd400, 32'd3, 32'd4, 2'd1, '0, 3, 1'b1, 1);
    check_eq("mis16_data", ld_data, 256'h0201);
    run_cmd("mis32", 1'b0, 32'd402, 32'd4, 32'd4, 2'd2, '0, 1, 1'b1, 0);
    check_eq("mis32_data", ld_data, 256'(0));

    // vl clamped to VLEN/32 = 8 lanes
    run_cmd("clamp", 1'b0, 32'd400, 32'd4, 32'd20, 2'd2, '0, 17, 1'b0, 8);
    exp_v = '0;
    for (int i = 0; i < 8; i++) exp_v[32*i +: 32] = init_word(100 + i);
    check_eq("clamp_data", ld_data, exp_v);

    // vl 0, and reserved SEW 3 behaving as SEW32
    run_cmd("vl0", 1'b0, 32'd400, 32'd4, 32'd0, 2'd0, '0, 1, 1'b0, 0);
    run_cmd("sew3", 1'b0, 32'd404, 32'd4, 32'd1, 2'd3, '0, 3, 1'b0, 1);
    check_eq("sew3_data", ld_data, 256'h08070605);

    // Stride 0 SEW8 store to byte 1 of word 200
    run_cmd("str0", 1'b1, 32'd801, 32'd0, 32'd3, 2'd0, 256'hCCBBAA, 7, 1'b0, 3);
    check_eq("str0_addr", 256'({log_addr[7'(t0)], log_addr[7'(t0 + 2)]}), 256'({32'd800, 32'd800}));
    check_eq("str0_wstrb", 256'({log_wstrb[7'(t0)], log_wstrb[7'(t0 + 2)]}), 256'(8'b0010_0010));
    check_eq("str0_wdata", 256'({log_wdata[7'(t0)], log_wdata[7'(t0 + 1)], log_wdata[7'(t0 + 2)]}),
             256'({32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC}));
    check_eq("str0_mem", 256'(mem[200]), 256'(32'hA500_CCC8));

    // Reset during element 2 of a vl-8 store
    @(negedge clk);
    t0 = n_txn;
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_base = 32'd700; cmd_stride = 32'd4;
    cmd_vl = 32'd8; cmd_sew = 2'd0; st_data = 256'h0807060504030201;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int g = 0; g < 100 && n_txn < t0 + 2; g++) @(negedge clk);
    check_eq("rst_wait", 256'(n_txn - t0), 256'(2));
    @(negedge clk);
    check_eq("rst_pre", 256'({bus.mem_valid, bus.mem_addr}), 256'({1'b1, 32'd708}));
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_bus", 256'({bus.mem_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}), 256'(0));
    check_eq("rst_mid_st", 256'({cmd_ready, done, err}), 256'(3'b100));
    repeat (2) @(negedge clk);
    check_eq("rst_no_txn", 256'(n_txn - t0), 256'(2));
    check_eq("rst_kept", 256'({mem[175], mem[176], mem[177]}),
             256'({32'hA500_0001, 32'hA500_0002, 32'hA500_00B1}));
    resetn = 1'b1;

    run_cmd("post", 1'b0, 32'd400, 32'd2, 32'd8, 2'd0, '0, 17, 1'b0, 8);
    check_eq("post_data", ld_data, 256'h0f0d0b0907050301);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
